// File: rtl/cpu_pkg.sv
// Shared types for the single-bus CPU datapath: widths, bus-source ordering, immediate extension.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam int IMM_W  = 19;

    // Bus sources in descending priority: the first enumerator after
    // SRC_NONE wins when several drive strobes are asserted together.
    // SRC_REG covers R0..R15, where the lowest index wins.
    typedef enum logic [3:0] {
        SRC_NONE,
        SRC_MDR,
        SRC_PC,
        SRC_ZLOW,
        SRC_ZHIGH,
        SRC_HI,
        SRC_LO,
        SRC_INPORT,
        SRC_C,
        SRC_REG
    } bus_src_t;

    // The C operand is the low IMM_W bits of IR, sign-extended to a full word.
    function automatic logic [WORD_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/reg32.sv
// Word register clocked on the falling edge, with synchronous clear and load enable.
// Latency: one falling edge from en/d to q.
// Backpressure: none; loads whenever en is high, and clr overrides en.
module reg32
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    // Clear takes precedence over load; otherwise hold.
    always_ff @(negedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit datapath: registers around one priority-muxed bus and a small ALU into a 64-bit Z.
// Latency: bus and C are combinational; every register load takes effect at the next falling edge.
// Backpressure: none; an external sequencer drives one-hot strobes. DATAPATH_FULL_REGFILE_EN exposes R0-R15 and HI/LO loads.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic [WORD_W-1:0] MDatain,
    input  logic [WORD_W-1:0] InPort_in,
    input  logic              Read,
    input  logic              PCout,
    input  logic              Zlowout,
    input  logic              Zhighout,
    input  logic              MDRout,
    input  logic              HIout,
    input  logic              LOout,
    input  logic              InPortout,
    input  logic              Cout,
    input  logic              PCin,
    input  logic              IRin,
    input  logic              Yin,
    input  logic              Zin,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              IncPC,
    input  logic              ADD,
`ifdef DATAPATH_FULL_REGFILE_EN
    input  logic              R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic              R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic              R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic              R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic              HIin,
    input  logic              LOin,
`else
    input  logic              R2out,
    input  logic              R3out,
    input  logic              R7out,
    input  logic              R1in,
    input  logic              R2in,
    input  logic              R3in,
`endif
    output logic [WORD_W-1:0] BusMuxOut,
    output logic [WORD_W-1:0] PC_q,
    output logic [WORD_W-1:0] IR_q,
    output logic [WORD_W-1:0] MAR_q,
    output logic [WORD_W-1:0] R1_q,
    output logic [WORD_W-1:0] Zlow_q
);

    logic [WORD_W-1:0]   bus;
    logic [WORD_W-1:0]   c_val;
    logic [WORD_W-1:0]   y_q;
    logic [WORD_W-1:0]   mdr_q;
    logic [WORD_W-1:0]   mdr_d;
    logic [WORD_W-1:0]   zhigh_q;
    logic [WORD_W-1:0]   hi_q;
    logic [WORD_W-1:0]   lo_q;
    logic [WORD_W-1:0]   inport_q;
    logic [WORD_W-1:0]   r_q [16];
    logic [15:0]         r_out;
    logic [2*WORD_W-1:0] alu;
    bus_src_t            src;
    logic [3:0]          reg_idx;

    assign BusMuxOut = bus;
    assign R1_q      = r_q[1];
    assign c_val     = sext_imm(IR_q[IMM_W-1:0]);
    assign mdr_d     = Read ? MDatain : bus;

    // Special-purpose registers.
    reg32 u_pc     (.clk(clk), .clr(clr), .en(PCin),  .d(bus),           .q(PC_q));
    reg32 u_ir     (.clk(clk), .clr(clr), .en(IRin),  .d(bus),           .q(IR_q));
    reg32 u_y      (.clk(clk), .clr(clr), .en(Yin),   .d(bus),           .q(y_q));
    reg32 u_mar    (.clk(clk), .clr(clr), .en(MARin), .d(bus),           .q(MAR_q));
    reg32 u_mdr    (.clk(clk), .clr(clr), .en(MDRin), .d(mdr_d),         .q(mdr_q));
    reg32 u_zlow   (.clk(clk), .clr(clr), .en(Zin),   .d(alu[31:0]),     .q(Zlow_q));
    reg32 u_zhigh  (.clk(clk), .clr(clr), .en(Zin),   .d(alu[63:32]),    .q(zhigh_q));
    reg32 u_inport (.clk(clk), .clr(clr), .en(1'b1),  .d(InPort_in),     .q(inport_q));

`ifdef DATAPATH_FULL_REGFILE_EN
    logic [15:0] r_in;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    for (genvar i = 0; i < 16; i++) begin : g_regfile
        reg32 u_r (.clk(clk), .clr(clr), .en(r_in[i]), .d(bus), .q(r_q[i]));
    end

    reg32 u_hi (.clk(clk), .clr(clr), .en(HIin), .d(bus), .q(hi_q));
    reg32 u_lo (.clk(clk), .clr(clr), .en(LOin), .d(bus), .q(lo_q));
`else
    // Only R1-R3 are real storage; R7 can drive the bus but always reads 0.
    assign r_out = {8'b0, R7out, 3'b0, R3out, R2out, 2'b0};

    reg32 u_r1 (.clk(clk), .clr(clr), .en(R1in), .d(bus), .q(r_q[1]));
    reg32 u_r2 (.clk(clk), .clr(clr), .en(R2in), .d(bus), .q(r_q[2]));
    reg32 u_r3 (.clk(clk), .clr(clr), .en(R3in), .d(bus), .q(r_q[3]));

    for (genvar i = 0; i < 16; i++) begin : g_regfile_zero
        if (i == 0 || i > 3) begin : g_zero
            assign r_q[i] = '0;
        end
    end

    assign hi_q = '0;
    assign lo_q = '0;
`endif

    // Pick the single winning bus source; later assignments override earlier ones, so the highest priority comes last.
    always_comb begin
        src     = SRC_NONE;
        reg_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (r_out[i]) begin
                src     = SRC_REG;
                reg_idx = 4'(i);
            end
        end
        if (Cout)      src = SRC_C;
        if (InPortout) src = SRC_INPORT;
        if (LOout)     src = SRC_LO;
        if (HIout)     src = SRC_HI;
        if (Zhighout)  src = SRC_ZHIGH;
        if (Zlowout)   src = SRC_ZLOW;
        if (PCout)     src = SRC_PC;
        if (MDRout)    src = SRC_MDR;
    end

    // Route the selected source onto the shared bus; an idle bus reads 0.
    always_comb begin
        bus = '0;
        case (src)
            SRC_MDR:    bus = mdr_q;
            SRC_PC:     bus = PC_q;
            SRC_ZLOW:   bus = Zlow_q;
            SRC_ZHIGH:  bus = zhigh_q;
            SRC_HI:     bus = hi_q;
            SRC_LO:     bus = lo_q;
            SRC_INPORT: bus = inport_q;
            SRC_C:      bus = c_val;
            SRC_REG:    bus = r_q[reg_idx];
            default:    bus = '0;
        endcase
    end

    // ALU: increment wins over add; the add is done at 64 bits so Zhigh holds the sign/overflow word.
    always_comb begin
        alu = {{WORD_W{1'b0}}, bus};
        if (IncPC) begin
            alu = {{WORD_W{1'b0}}, bus + WORD_W'(1)};
        end else if (ADD) begin
            alu = {{WORD_W{y_q[WORD_W-1]}}, y_q} + {{WORD_W{bus[WORD_W-1]}}, bus};
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Randomized and directed stimulus for cpu_datapath against a behavioural model, scored by a queue-driven monitor.
// Latency: expects bus results in the same cycle and register results after the following falling edge.
// Backpressure: none.
module tb_cpu_datapath;

    localparam int PCOUT = 0,  ZLO = 1,    ZHI = 2,    MDROUT = 3, HIOUT = 4,  LOOUT = 5;
    localparam int INPOUT = 6, COUT = 7,   R2OUT = 8,  R3OUT = 9,  R7OUT = 10, PCIN = 11;
    localparam int IRIN = 12,  YIN = 13,   ZIN = 14,   MARIN = 15, MDRIN = 16, R1IN = 17;
    localparam int R2IN = 18,  R3IN = 19,  INCPC = 20, ADD_B = 21, READ = 22;

    typedef struct {
        logic [31:0] bus;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] mar;
        logic [31:0] r1;
        logic [31:0] zlo;
    } exp_t;

    logic        clk;
    logic        clr;
    logic [31:0] MDatain, InPort_in;
    logic        Read, PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout;
    logic        PCin, IRin, Yin, Zin, MARin, MDRin, IncPC, ADD;
    logic        R2out, R3out, R7out, R1in, R2in, R3in;
    logic [31:0] BusMuxOut, PC_q, IR_q, MAR_q, R1_q, Zlow_q;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    // Behavioural state of the datapath as seen from outside.
    logic [31:0] m_pc, m_ir, m_y, m_mar, m_mdr, m_r1, m_r2, m_r3, m_inport;
    logic [63:0] m_z;

    cpu_datapath dut (
        .clk(clk), .clr(clr), .MDatain(MDatain), .InPort_in(InPort_in), .Read(Read),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin),
        .IncPC(IncPC), .ADD(ADD),
        .R2out(R2out), .R3out(R3out), .R7out(R7out), .R1in(R1in), .R2in(R2in), .R3in(R3in),
        .BusMuxOut(BusMuxOut), .PC_q(PC_q), .IR_q(IR_q), .MAR_q(MAR_q), .R1_q(R1_q),
        .Zlow_q(Zlow_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [22:0] sb(input int i);
        return 23'd1 << i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Bus value from the source list, highest priority first.
    function automatic logic [31:0] model_bus(input logic [22:0] s);
        if (s[MDROUT])              return m_mdr;
        if (s[PCOUT])               return m_pc;
        if (s[ZLO])                 return m_z[31:0];
        if (s[ZHI])                 return m_z[63:32];
        if (s[HIOUT] || s[LOOUT])   return 32'd0;
        if (s[INPOUT])              return m_inport;
        if (s[COUT])                return {{13{m_ir[18]}}, m_ir[18:0]};
        if (s[R2OUT])               return m_r2;
        if (s[R3OUT])               return m_r3;
        return 32'd0;
    endfunction

    // Drive one cycle of strobes, advance the model, and queue the expected response.
    task automatic issue(input logic [22:0] s, input logic [31:0] md, input logic c);
        exp_t        e;
        logic [31:0] b, ip;
        logic [63:0] z_next;
        longint      sum;
        @(posedge clk);
        #1;
        ip = $urandom;
        {Read, ADD, IncPC, R3in, R2in, R1in, MDRin, MARin, Zin, Yin, IRin, PCin,
         R7out, R3out, R2out, Cout, InPortout, LOout, HIout, MDRout, Zhighout, Zlowout, PCout} = s;
        MDatain   = md;
        InPort_in = ip;
        clr       = c;
        b = model_bus(s);
        e.bus = b;
        if (c) begin
            m_pc = 0; m_ir = 0; m_y = 0; m_mar = 0; m_mdr = 0;
            m_r1 = 0; m_r2 = 0; m_r3 = 0; m_z = 0; m_inport = 0;
        end else begin
            z_next = m_z;
            if (s[ZIN]) begin
                if (s[INCPC]) begin
                    z_next = {32'd0, b + 32'd1};
                end else if (s[ADD_B]) begin
                    sum    = longint'($signed(m_y)) + longint'($signed(b));
                    z_next = sum;
                end else begin
                    z_next = {32'd0, b};
                end
            end
            m_z = z_next;
            if (s[MDRIN]) m_mdr = s[READ] ? md : b;
            if (s[PCIN])  m_pc  = b;
            if (s[IRIN])  m_ir  = b;
            if (s[YIN])   m_y   = b;
            if (s[MARIN]) m_mar = b;
            if (s[R1IN])  m_r1  = b;
            if (s[R2IN])  m_r2  = b;
            if (s[R3IN])  m_r3  = b;
            m_inport = ip;
        end
        e.pc = m_pc; e.ir = m_ir; e.mar = m_mar; e.r1 = m_r1; e.zlo = m_z[31:0];
        exp_q.push_back(e);
    endtask

    // Monitor: bus checked mid-cycle, registers checked just after the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("bus", BusMuxOut, e.bus);
                @(negedge clk);
                #2;
                chk("pc", PC_q, e.pc);
                chk("ir", IR_q, e.ir);
                chk("mar", MAR_q, e.mar);
                chk("r1", R1_q, e.r1);
                chk("zlow", Zlow_q, e.zlo);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [22:0] s;
        logic [31:0] md;
        int          pick;
        clr = 1'b1;
        MDatain = 0; InPort_in = 0;
        {Read, ADD, IncPC, R3in, R2in, R1in, MDRin, MARin, Zin, Yin, IRin, PCin,
         R7out, R3out, R2out, Cout, InPortout, LOout, HIout, MDRout, Zhighout, Zlowout, PCout} = '0;
        m_pc = 0; m_ir = 0; m_y = 0; m_mar = 0; m_mdr = 0;
        m_r1 = 0; m_r2 = 0; m_r3 = 0; m_z = 0; m_inport = 0;

        issue('0, 32'd0, 1'b1);
        issue('0, 32'd0, 1'b1);

        // R1 = 5 + (-10) through Y and ADD.
        issue(sb(READ) | sb(MDRIN), 32'd5, 1'b0);
        issue(sb(MDROUT) | sb(R2IN), 32'd0, 1'b0);
        issue(sb(READ) | sb(MDRIN), 32'hFFFF_FFF6, 1'b0);
        issue(sb(MDROUT) | sb(R3IN), 32'd0, 1'b0);
        issue(sb(R2OUT) | sb(YIN), 32'd0, 1'b0);
        issue(sb(R3OUT) | sb(ADD_B) | sb(ZIN), 32'd0, 1'b0);
        issue(sb(ZLO) | sb(R1IN), 32'd0, 1'b0);
        @(negedge clk); #2;
        chk("add_r1", R1_q, 32'hFFFF_FFFB);
        issue(sb(ZHI), 32'd0, 1'b0);
        #2;
        chk("add_zhigh", BusMuxOut, 32'hFFFF_FFFF);

        // PC increment through Z.
        issue(sb(PCIN), 32'd0, 1'b0);
        issue(sb(PCOUT) | sb(MARIN) | sb(INCPC) | sb(ZIN), 32'd0, 1'b0);
        issue(sb(ZLO) | sb(PCIN), 32'd0, 1'b0);
        @(negedge clk); #2;
        chk("inc_mar", MAR_q, 32'd0);
        chk("inc_pc", PC_q, 32'd1);

        // Immediate C, positive and negative.
        issue(sb(READ) | sb(MDRIN), 32'h2891_8000, 1'b0);
        issue(sb(MDROUT) | sb(IRIN), 32'd0, 1'b0);
        issue(sb(COUT), 32'd0, 1'b0);
        #2;
        chk("c_pos", BusMuxOut, 32'h0001_8000);
        @(negedge clk); #2;
        chk("ir_load", IR_q, 32'h2891_8000);
        issue(sb(READ) | sb(MDRIN), 32'h0004_0000, 1'b0);
        issue(sb(MDROUT) | sb(IRIN), 32'd0, 1'b0);
        issue(sb(COUT), 32'd0, 1'b0);
        #2;
        chk("c_neg", BusMuxOut, 32'hFFFC_0000);

        // Priority and idle bus.
        issue(sb(PCOUT) | sb(MDROUT), 32'd0, 1'b0);
        #2;
        chk("prio_mdr", BusMuxOut, 32'h0004_0000);
        issue('0, 32'd0, 1'b0);
        #2;
        chk("idle_bus", BusMuxOut, 32'd0);

        // PC wrap at all-ones.
        issue(sb(READ) | sb(MDRIN), 32'hFFFF_FFFF, 1'b0);
        issue(sb(MDROUT) | sb(PCIN) | sb(R1IN), 32'd0, 1'b0);
        issue(sb(PCOUT) | sb(INCPC) | sb(ZIN), 32'd0, 1'b0);
        issue(sb(ZLO) | sb(PCIN), 32'd0, 1'b0);
        @(negedge clk); #2;
        chk("pc_wrap", PC_q, 32'd0);

        // Reset mid-sequence beats loads.
        issue(sb(MDROUT) | sb(ZIN) | sb(R1IN) | sb(PCIN), 32'd0, 1'b1);
        @(negedge clk); #2;
        chk("clr_r1", R1_q, 32'd0);
        chk("clr_zlow", Zlow_q, 32'd0);
        chk("clr_pc", PC_q, 32'd0);
        issue(sb(MDROUT), 32'd0, 1'b0);
        #2;
        chk("clr_mdr", BusMuxOut, 32'd0);
        issue(sb(ZHI), 32'd0, 1'b0);
        #2;
        chk("clr_zhigh", BusMuxOut, 32'd0);

        // Random strobe soup, occasional reset, corner data values.
        for (int n = 0; n < 600; n++) begin
            s    = 23'($urandom);
            pick = $urandom_range(0, 7);
            md   = (pick == 0) ? 32'hFFFF_FFFF : (pick == 1) ? 32'h8000_0000 :
                   (pick == 2) ? 32'h7FFF_FFFF : $urandom;
            issue(s, md, ($urandom_range(0, 31) == 0));
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
